aes_req_scheduler: RTL and testbench
====================================

# aes_req_scheduler

Request scheduler and sequencer in front of the iterative `AES_top` encryption core. Accepts {plaintext, key} jobs from `NREQ` requesters over valid/ready, grants one at a time by round-robin, and launches the core with a single-cycle start. It waits for core completion or a watchdog timeout, then returns the ciphertext tagged with the requester index on a valid/ready response channel. It is the only block that drives the core's inputs.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `DATA_W`, 128: plaintext/key/ciphertext width.
- `TIMEOUT`, 64: max cycles in BUSY before the job is aborted (≥ 2).
- `ID_W`, $clog2(NREQ): requester tag width.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester job valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high (the granted one).
- `req_pt`  in  NREQ*DATA_W  plaintext; requester i occupies slice [i*DATA_W +: DATA_W].
- `req_key`  in  NREQ*DATA_W  key, same packing.
- `core_start`  out  1  one-cycle launch pulse to the core.
- `core_pt`, `core_key`  out  DATA_W each  operands to the core; held stable for the whole job.
- `core_done`  in  1  one-cycle completion pulse from the core.
- `core_ct`  in  DATA_W  ciphertext; valid when `core_done` is high.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  ID_W  index of the requester that owns the response.
- `resp_data`  out  DATA_W  ciphertext, or 0 when `resp_err` is high.
- `resp_err`  out  1  job aborted by timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - The round-robin arbiter picks the first requester with `req_valid` set, searching upward from `last_grant+1` with wrap-around.
  - `req_ready[g]` is high combinationally, for the chosen g only.
  - On handshake, register pt, key and id=g, set `last_grant`=g, and go to LAUNCH.
- LAUNCH: `core_start`=1 for exactly one cycle, clear the timeout counter, go to BUSY.
- BUSY:
  - `core_done`=1: capture `core_ct` into `resp_data`, set `resp_err`=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 with no done: `resp_data`=0, `resp_err`=1, go to RESP.
  - If done and the timeout fire in the same cycle, done wins.
- RESP: `resp_valid`=1. Hold `resp_valid`, `resp_id`, `resp_data` and `resp_err` stable until `resp_ready`. On handshake go to IDLE.
- `req_ready` is 0 in LAUNCH, BUSY and RESP. No new job is accepted in the cycle a response handshakes.
- `core_done` is ignored outside BUSY. This covers late dones after a timeout.
- `core_pt`/`core_key` come from the job registers and change only on a request handshake.
- Deassertion of `req_valid` by a non-granted requester has no effect. A granted job cannot be withdrawn.

## Timing
- Reset values:
  - State = IDLE.
  - `last_grant` = NREQ-1, so requester 0 wins first.
  - All outputs 0: `req_ready`, `core_start`, `core_pt`, `core_key`, `resp_valid`, `resp_id`, `resp_data`, `resp_err`, `busy`.
- Reset mid-job: return to IDLE immediately and drop the job with no response. The core is reset by the same `rst`.
- Request handshake in cycle N: `core_start` is high in N+1, and BUSY begins in N+2.
- `core_done` in cycle D: `resp_valid` is high from D+1.
- Back-to-back throughput: 1 (accept) + 1 (launch) + core latency + 1 (response, minimum) cycles per job.
- Timeout: first BUSY cycle is counter=0. Abort at the edge after the cycle in which counter=`TIMEOUT`-1, so `resp_valid` rises `TIMEOUT` cycles after BUSY entry.

## Structure
- Package `aes_sched_pkg` holds:
  - the state enum (IDLE, LAUNCH, BUSY, RESP);
  - the default `DATA_W`/`TIMEOUT` constants;
  - a function computing `ID_W` from `NREQ`.
- One sub-module, `rr_arbiter`:
  - Inputs: `NREQ`-bit request vector and the `last_grant` pointer.
  - Outputs: one-hot grant and its index.
  - Purely combinational. The pointer register lives in the top.

## Test plan
- Single job, requester 0: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f. Require `core_start` exactly one cycle after accept, then `resp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `resp_id`=0, `resp_err`=0.
- Fairness: both requesters hold `req_valid` continuously for 4 jobs. Require grant order 0,1,0,1 and never two `req_ready` bits high at once.
- Backpressure: hold `resp_ready`=0 for 10 cycles after the response. Require `resp_*` stable throughout, `req_ready`=0 throughout, and the next accept only after the handshake.
- Timeout: a stub core never asserts done, with `TIMEOUT`=8. Require `resp_valid` 8 cycles after BUSY entry with `resp_err`=1 and `resp_data`=0. A late `core_done` while in IDLE must be ignored.
- Done/timeout collision: `core_done` in the final counted cycle. Require `resp_err`=0 and the ciphertext captured.
- Reset mid-BUSY: pull `rst` low for 2 cycles. Require all outputs 0 and no response. After release, requester 0 wins first regardless of prior `last_grant`.

Source files
------------

// File: rtl/aes_req_scheduler_pkg.sv
// Shared types and constants for the AES request scheduler.
package aes_sched_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 128;
    localparam int DEF_TIMEOUT = 64;

    // Width of the requester tag; never narrower than one bit
    function automatic int calcIdW(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/aes_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last grant + 1.
module rr_arbiter
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = calcIdW(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_valid
);

    logic [ID_W-1:0] w_cand;

    // Pick the first active request after the previous winner, with wrap-around
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = ID_W'((int'(i_last) + k) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Round-robin job scheduler and launch/response sequencer for the AES core.
module aes_req_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ID_W    = calcIdW(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_pt,
    input  logic [NREQ*DATA_W-1:0] req_key,
    output logic                   core_start,
    output logic [DATA_W-1:0]      core_pt,
    output logic [DATA_W-1:0]      core_key,
    input  logic                   core_done,
    input  logic [DATA_W-1:0]      core_ct,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            r_state;
    state_t            w_nextState;
    logic [ID_W-1:0]   r_lastGrant;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_pt;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_respData;
    logic              r_respErr;
    logic [CNT_W-1:0]  r_cnt;

    logic [NREQ-1:0]   w_grant;
    logic [ID_W-1:0]   w_idx;
    logic              w_anyReq;
    logic              w_reqFire;
    logic              w_timeout;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_last  (r_lastGrant),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_anyReq)
    );

    // Grant is only exposed while idle; a job is accepted whenever it is shown
    always_comb begin
        req_ready = '0;
        w_reqFire = 1'b0;
        if (r_state == S_IDLE) begin
            req_ready = w_grant;
            w_reqFire = w_anyReq;
        end
        w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    end

    // Next-state logic; completion takes priority over the watchdog
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_reqFire) w_nextState = S_LAUNCH;
            S_LAUNCH: w_nextState = S_BUSY;
            S_BUSY:   if (core_done || w_timeout) w_nextState = S_RESP;
            S_RESP:   if (resp_ready) w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nextState;
    end

    // Capture the granted job's operands and remember who won
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pt        <= '0;
            r_key       <= '0;
            r_id        <= '0;
            r_lastGrant <= ID_W'(NREQ - 1);
        end else if (w_reqFire) begin
            r_pt        <= req_pt[w_idx*DATA_W +: DATA_W];
            r_key       <= req_key[w_idx*DATA_W +: DATA_W];
            r_id        <= w_idx;
            r_lastGrant <= w_idx;
        end
    end

    // Watchdog counter: cleared at launch, counts each BUSY cycle without done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY && !core_done && !w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Response payload: ciphertext on completion, zero plus error flag on abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_respData <= '0;
            r_respErr  <= 1'b0;
        end else if (r_state == S_BUSY) begin
            if (core_done) begin
                r_respData <= core_ct;
                r_respErr  <= 1'b0;
            end else if (w_timeout) begin
                r_respData <= '0;
                r_respErr  <= 1'b1;
            end
        end
    end

    assign core_start = (r_state == S_LAUNCH);
    assign core_pt    = r_pt;
    assign core_key   = r_key;
    assign resp_valid = (r_state == S_RESP);
    assign resp_id    = r_id;
    assign resp_data  = r_respData;
    assign resp_err   = r_respErr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed self-checking bench for aes_req_scheduler with a stub AES core.
module tb_aes_req_scheduler;

   localparam int NREQ    = 2;
   localparam int DATA_W  = 128;
   localparam int TIMEOUT = 8;
   localparam int ID_W    = 1;

   localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1  = 128'hdeadbeef0123456789abcdeffeedface;
   localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] CT1  = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
   localparam logic [127:0] CT2  = 128'h1234567890abcdef1122334455667788;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*DATA_W-1:0] req_pt;
   logic [NREQ*DATA_W-1:0] req_key;
   logic                   core_start;
   logic [DATA_W-1:0]      core_pt;
   logic [DATA_W-1:0]      core_key;
   logic                   core_done;
   logic [DATA_W-1:0]      core_ct;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [ID_W-1:0]        resp_id;
   logic [DATA_W-1:0]      resp_data;
   logic                   resp_err;
   logic                   busy;

   int checks = 0;
   int errors = 0;

   aes_req_scheduler #(
      .NREQ    (NREQ),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .ID_W    (ID_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pt     (req_pt),
      .req_key    (req_key),
      .core_start (core_start),
      .core_pt    (core_pt),
      .core_key   (core_key),
      .core_done  (core_done),
      .core_ct    (core_ct),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on mismatch
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive the stimulus-side inputs and let combinational outputs settle
   task automatic applyStimulus(input logic [1:0] valid, input logic done,
                                input logic [127:0] ct, input logic rready);
      req_valid  = valid;
      core_done  = done;
      core_ct    = ct;
      resp_ready = rready;
      #1;
   endtask

   // Every output must be zero (reset state)
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_req_ready"}, req_ready, 0);
      checkOutput({tag, "_core_start"}, core_start, 0);
      checkOutput({tag, "_core_pt"}, core_pt, 0);
      checkOutput({tag, "_core_key"}, core_key, 0);
      checkOutput({tag, "_resp_valid"}, resp_valid, 0);
      checkOutput({tag, "_resp_id"}, resp_id, 0);
      checkOutput({tag, "_resp_data"}, resp_data, 0);
      checkOutput({tag, "_resp_err"}, resp_err, 0);
      checkOutput({tag, "_busy"}, busy, 0);
   endtask

   // Full job from an idle falling edge: accept, launch, done after
   // doneDelay BUSY cycles, optional response backpressure, handshake
   task automatic runJob(input string tag, input int g, input logic [1:0] validIn,
                         input logic [1:0] validAfter, input int doneDelay,
                         input logic [127:0] ct, input int holdCycles);
      applyStimulus(validIn, 1'b0, '0, 1'b0);
      checkOutput({tag, "_grant"}, req_ready, 128'(1) << g);
      checkOutput({tag, "_onehot"}, 128'($countones(req_ready) <= 1), 1);
      checkOutput({tag, "_idle_start"}, core_start, 0);
      @(negedge clk);
      applyStimulus(validAfter, 1'b0, '0, 1'b0);
      checkOutput({tag, "_launch_start"}, core_start, 1);
      checkOutput({tag, "_launch_ready"}, req_ready, 0);
      checkOutput({tag, "_core_pt"}, core_pt, (g == 0) ? PT0 : PT1);
      checkOutput({tag, "_core_key"}, core_key, (g == 0) ? KEY0 : KEY1);
      @(negedge clk);
      checkOutput({tag, "_busy_start"}, core_start, 0);
      checkOutput({tag, "_busy"}, busy, 1);
      repeat (doneDelay) @(negedge clk);
      applyStimulus(validAfter, 1'b1, ct, 1'b0);
      @(negedge clk);
      applyStimulus(validAfter, 1'b0, '0, 1'b0);
      checkOutput({tag, "_resp_valid"}, resp_valid, 1);
      checkOutput({tag, "_resp_id"}, resp_id, 128'(g));
      checkOutput({tag, "_resp_data"}, resp_data, ct);
      checkOutput({tag, "_resp_err"}, resp_err, 0);
      checkOutput({tag, "_resp_ready"}, req_ready, 0);
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, resp_valid, 1);
         checkOutput({tag, "_hold_id"}, resp_id, 128'(g));
         checkOutput({tag, "_hold_data"}, resp_data, ct);
         checkOutput({tag, "_hold_err"}, resp_err, 0);
         checkOutput({tag, "_hold_req_ready"}, req_ready, 0);
      end
      applyStimulus(validAfter, 1'b0, '0, 1'b1);
      checkOutput({tag, "_hs_req_ready"}, req_ready, 0);
      @(negedge clk);
      applyStimulus(validAfter, 1'b0, '0, 1'b0);
      checkOutput({tag, "_after_resp_valid"}, resp_valid, 0);
      checkOutput({tag, "_after_busy"}, busy, 0);
   endtask

   // Directed scenario sequence
   initial begin
      rst     = 1'b0;
      req_pt  = {PT1, PT0};
      req_key = {KEY1, KEY0};
      applyStimulus(2'b00, 1'b0, '0, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Single job from requester 0 with the FIPS-197 vector
      runJob("single", 0, 2'b01, 2'b00, 3, CT0, 0);

      // Backpressure on requester 1's response while both requesters wait
      runJob("bp", 1, 2'b10, 2'b11, 2, CT1, 10);

      // Fairness: both requesters held valid, expect 0,1,0,1
      runJob("fair0", 0, 2'b11, 2'b11, 0, CT0, 0);
      runJob("fair1", 1, 2'b11, 2'b11, 1, CT1, 0);
      runJob("fair2", 0, 2'b11, 2'b11, 0, CT2, 0);
      runJob("fair3", 1, 2'b11, 2'b00, 2, CT0, 0);

      // Timeout: no done from the core
      applyStimulus(2'b01, 1'b0, '0, 1'b0);
      checkOutput("to_grant", req_ready, 1);
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, '0, 1'b0);
      checkOutput("to_launch", core_start, 1);
      @(negedge clk);
      checkOutput("to_busy", busy, 1);
      repeat (TIMEOUT - 1) @(negedge clk);
      checkOutput("to_last_count_valid", resp_valid, 0);
      @(negedge clk);
      checkOutput("to_resp_valid", resp_valid, 1);
      checkOutput("to_resp_err", resp_err, 1);
      checkOutput("to_resp_data", resp_data, 0);
      checkOutput("to_resp_id", resp_id, 0);
      applyStimulus(2'b00, 1'b0, '0, 1'b1);
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, '0, 1'b0);
      checkOutput("to_after_valid", resp_valid, 0);

      // Late done while idle is ignored
      applyStimulus(2'b00, 1'b1, CT1, 1'b0);
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, '0, 1'b0);
      checkOutput("late_done_valid", resp_valid, 0);
      checkOutput("late_done_busy", busy, 0);
      @(negedge clk);
      checkOutput("late_done_valid2", resp_valid, 0);

      // Done coincides with the final counted cycle: done wins
      runJob("collide", 1, 2'b10, 2'b00, TIMEOUT - 1, CT2, 0);

      // Reset in the middle of BUSY after requester 0 was last granted
      applyStimulus(2'b01, 1'b0, '0, 1'b0);
      checkOutput("rstjob_grant", req_ready, 1);
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkOutput("rstjob_busy", busy, 1);
      rst = 1'b0;
      #1;
      checkAllZero("midrst_a");
      @(negedge clk);
      checkAllZero("midrst_b");
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(2'b00, 1'b1, CT1, 1'b0);
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, '0, 1'b0);
      checkOutput("postrst_no_resp", resp_valid, 0);
      checkOutput("postrst_busy", busy, 0);
      @(negedge clk);
      checkOutput("postrst_no_resp2", resp_valid, 0);

      // Both requesting after reset: requester 0 must win first
      runJob("postrst", 0, 2'b11, 2'b00, 1, CT0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
